// File: rtl/traffic_light_pkg.sv
// Shared encodings for the dual-road traffic light controller and its monitor.
package traffic_light_pkg;

   // Lamp phase encoding, one per road.
   localparam logic [1:0] RED     = 2'd0;
   localparam logic [1:0] GREEN   = 2'd1;
   localparam logic [1:0] YELLOW  = 2'd2;
   localparam logic [1:0] INVALID = 2'd3;

   // Monitor FSM state codes.
   localparam logic [1:0] SYNC  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] FAULT = 2'd2;

   // Map a {red,yellow,green} lamp triple onto a phase code.
   function automatic logic [1:0] decode_phase(input logic r, input logic y, input logic g);
      logic [1:0] p;
      case ({r, y, g})
         3'b100:  p = RED;
         3'b001:  p = GREEN;
         3'b010:  p = YELLOW;
         default: p = INVALID;
      endcase
      return p;
   endfunction

   // True when moving from one valid phase to a different valid phase is allowed.
   function automatic logic legal_step(input logic [1:0] from, input logic [1:0] to);
      logic ok;
      case ({from, to})
         {RED, GREEN}:    ok = 1'b1;
         {GREEN, YELLOW}: ok = 1'b1;
         {YELLOW, RED}:   ok = 1'b1;
         default:         ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/traffic_light_monitor_tracker.sv
// Per-road lamp tracker: decodes the lamp triple, remembers the last phase and
// its dwell time, and raises raw (ungated, combinational) error strobes for
// the current sample. The owner decides whether the strobes count.
module lamp_phase_tracker
   import traffic_light_pkg::*;
#(
   parameter int MIN_GREEN  = 3,
   parameter int MAX_GREEN  = 16,
   parameter int MIN_YELLOW = 2,
   parameter int MAX_YELLOW = 4,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       red,
   input  logic       yellow,
   input  logic       green,
   input  logic       sync_load,
   output logic [1:0] phase_now,
   output logic [1:0] phase,
   output logic       err_onehot,
   output logic       err_sequence,
   output logic       err_timing
);

   localparam logic [CNT_W-1:0] MIN_G     = CNT_W'(MIN_GREEN);
   localparam logic [CNT_W-1:0] MAX_G     = CNT_W'(MAX_GREEN);
   localparam logic [CNT_W-1:0] MIN_Y     = CNT_W'(MIN_YELLOW);
   localparam logic [CNT_W-1:0] MAX_Y     = CNT_W'(MAX_YELLOW);
   localparam logic [CNT_W-1:0] DWELL_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] DWELL_SAT = {CNT_W{1'b1}};

   logic [1:0]       phase_r;
   logic [CNT_W-1:0] dwell_r;
   logic [CNT_W-1:0] dwell_next_s;
   logic             changed_s;
   logic             both_valid_s;

   assign phase = phase_r;

   // Decode the sample and derive the per-road error strobes and next dwell.
   always_comb begin
      phase_now    = decode_phase(red, yellow, green);
      changed_s    = (phase_now != phase_r);
      both_valid_s = (phase_now != INVALID) && (phase_r != INVALID);
      err_onehot   = (phase_now == INVALID);
      err_sequence = 1'b0;
      err_timing   = 1'b0;
      dwell_next_s = dwell_r;

      if (both_valid_s && changed_s) begin
         err_sequence = !legal_step(phase_r, phase_now);
         if (phase_r == GREEN && dwell_r < MIN_G) begin
            err_timing = 1'b1;
         end else if (phase_r == YELLOW && dwell_r < MIN_Y) begin
            err_timing = 1'b1;
         end else begin
            err_timing = 1'b0;
         end
      end else if (!changed_s) begin
         // Hold: fires only on the sample where dwell would pass MAX, so once
         // per phase occurrence (dwell keeps counting past MAX afterwards).
         if (phase_now == GREEN && dwell_r == MAX_G) begin
            err_timing = 1'b1;
         end else if (phase_now == YELLOW && dwell_r == MAX_Y) begin
            err_timing = 1'b1;
         end else begin
            err_timing = 1'b0;
         end
      end else begin
         err_timing = 1'b0;
      end

      if (phase_now == INVALID) begin
         dwell_next_s = '0;
      end else if (sync_load || changed_s) begin
         dwell_next_s = DWELL_ONE;
      end else if (dwell_r == DWELL_SAT) begin
         dwell_next_s = dwell_r;
      end else begin
         dwell_next_s = dwell_r + DWELL_ONE;
      end
   end

   // Phase register and saturating dwell counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_r <= RED;
         dwell_r <= '0;
      end else begin
         phase_r <= phase_now;
         dwell_r <= dwell_next_s;
      end
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive monitor for the dual-road traffic light controller lamps. Two phase
// trackers feed a conflict check, a SYNC/RUN/FAULT FSM, a sticky fault and a
// completed-cycle counter. All outputs are registered.
module traffic_light_monitor
   import traffic_light_pkg::*;
#(
   parameter int MIN_GREEN  = 3,
   parameter int MAX_GREEN  = 16,
   parameter int MIN_YELLOW = 2,
   parameter int MAX_YELLOW = 4,
   parameter int CNT_W      = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ns_red,
   input  logic        ns_yellow,
   input  logic        ns_green,
   input  logic        ew_red,
   input  logic        ew_yellow,
   input  logic        ew_green,
   input  logic        err_clear,
   output logic [1:0]  ns_phase,
   output logic [1:0]  ew_phase,
   output logic        err_onehot,
   output logic        err_conflict,
   output logic        err_sequence,
   output logic        err_timing,
   output logic        fault,
   output logic [15:0] cycle_count
);

   logic [1:0]  state_r;
   logic [1:0]  state_next_s;
   logic [1:0]  ns_now_s;
   logic [1:0]  ew_now_s;
   logic        ns_onehot_s, ns_seq_s, ns_tim_s;
   logic        ew_onehot_s, ew_seq_s, ew_tim_s;
   logic        sync_ok_s;
   logic        sync_load_s;
   logic        check_en_s;
   logic        onehot_s, conflict_s, sequence_s, timing_s;
   logic        any_err_s;
   logic        fault_next_s;
   logic        count_s;

   lamp_phase_tracker #(
      .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
      .MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW), .CNT_W(CNT_W)
   ) u_ns (
      .clk(clk), .rst_n(rst_n),
      .red(ns_red), .yellow(ns_yellow), .green(ns_green),
      .sync_load(sync_load_s),
      .phase_now(ns_now_s), .phase(ns_phase),
      .err_onehot(ns_onehot_s), .err_sequence(ns_seq_s), .err_timing(ns_tim_s)
   );

   lamp_phase_tracker #(
      .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
      .MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW), .CNT_W(CNT_W)
   ) u_ew (
      .clk(clk), .rst_n(rst_n),
      .red(ew_red), .yellow(ew_yellow), .green(ew_green),
      .sync_load(sync_load_s),
      .phase_now(ew_now_s), .phase(ew_phase),
      .err_onehot(ew_onehot_s), .err_sequence(ew_seq_s), .err_timing(ew_tim_s)
   );

   // Gate the raw strobes by FSM state and decide the next state and fault.
   always_comb begin
      sync_ok_s   = (ns_now_s != INVALID) && (ew_now_s != INVALID) &&
                    ((ns_now_s == RED) || (ew_now_s == RED));
      sync_load_s = (state_r == SYNC) && sync_ok_s;
      // A clear in FAULT wins over anything seen on the same sample.
      check_en_s  = (state_r == RUN) || ((state_r == FAULT) && !err_clear);
      onehot_s    = check_en_s && (ns_onehot_s || ew_onehot_s);
      conflict_s  = check_en_s && (ns_now_s != RED) && (ew_now_s != RED);
      sequence_s  = check_en_s && (ns_seq_s || ew_seq_s);
      timing_s    = check_en_s && (ns_tim_s || ew_tim_s);
      any_err_s   = onehot_s || conflict_s || sequence_s || timing_s;
      count_s     = (state_r == RUN) && (ns_phase == YELLOW) && (ns_now_s == RED);

      case (state_r)
         SYNC: begin
            fault_next_s = 1'b0;
            if (sync_ok_s) begin
               state_next_s = RUN;
            end else begin
               state_next_s = SYNC;
            end
         end
         RUN: begin
            fault_next_s = any_err_s;
            if (any_err_s) begin
               state_next_s = FAULT;
            end else begin
               state_next_s = RUN;
            end
         end
         FAULT: begin
            if (err_clear) begin
               state_next_s = SYNC;
               fault_next_s = 1'b0;
            end else begin
               state_next_s = FAULT;
               fault_next_s = 1'b1;
            end
         end
         default: begin
            state_next_s = SYNC;
            fault_next_s = 1'b0;
         end
      endcase
   end

   // FSM state, registered error pulses, sticky fault and cycle counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= SYNC;
         err_onehot   <= 1'b0;
         err_conflict <= 1'b0;
         err_sequence <= 1'b0;
         err_timing   <= 1'b0;
         fault        <= 1'b0;
         cycle_count  <= 16'd0;
      end else begin
         state_r      <= state_next_s;
         err_onehot   <= onehot_s;
         err_conflict <= conflict_s;
         err_sequence <= sequence_s;
         err_timing   <= timing_s;
         fault        <= fault_next_s;
         if (count_s) begin
            cycle_count <= cycle_count + 16'd1;
         end else begin
            cycle_count <= cycle_count;
         end
      end
   end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with hand-computed expectations.
module tb_traffic_light_monitor;

   localparam logic [2:0] L_R = 3'b100;   // {red,yellow,green}
   localparam logic [2:0] L_Y = 3'b010;
   localparam logic [2:0] L_G = 3'b001;
   localparam logic [2:0] L_BAD = 3'b110;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ns_red, ns_yellow, ns_green;
   logic        ew_red, ew_yellow, ew_green;
   logic        err_clear;
   logic [1:0]  ns_phase, ew_phase;
   logic        err_onehot, err_conflict, err_sequence, err_timing, fault;
   logic [15:0] cycle_count;

   int checks = 0;
   int errors = 0;

   traffic_light_monitor dut (
      .clk(clk), .rst_n(rst_n),
      .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
      .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
      .err_clear(err_clear),
      .ns_phase(ns_phase), .ew_phase(ew_phase),
      .err_onehot(err_onehot), .err_conflict(err_conflict),
      .err_sequence(err_sequence), .err_timing(err_timing),
      .fault(fault), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Error pulses packed as {onehot, conflict, sequence, timing}.
   task automatic check_errs(input string tag, input logic [3:0] exp);
      check(tag, {12'd0, err_onehot, err_conflict, err_sequence, err_timing}, {12'd0, exp});
   endtask

   // Drive one lamp sample, clock it in, and settle just after the edge.
   task automatic apply(input logic [2:0] n, input logic [2:0] e, input logic clr);
      {ns_red, ns_yellow, ns_green} = n;
      {ew_red, ew_yellow, ew_green} = e;
      err_clear = clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] n, e;
      rst_n = 1'b0;
      {ns_red, ns_yellow, ns_green} = 3'b000;
      {ew_red, ew_yellow, ew_green} = 3'b000;
      err_clear = 1'b0;
      #12;
      check_errs("reset_errs", 4'b0000);
      check("reset_fault", {15'd0, fault}, 16'd0);
      check("reset_phases", {12'd0, ns_phase, ew_phase}, 16'd0);
      check("reset_count", cycle_count, 16'd0);
      rst_n = 1'b1;

      // 1: legal traffic, three full cycles of NS G4/Y2/R8 with EW mirrored
      apply(L_R, L_R, 1'b0);
      for (int c = 0; c < 3; c++) begin
         for (int t = 0; t < 14; t++) begin
            n = (t < 4) ? L_G : (t < 6) ? L_Y : L_R;
            e = (t < 7) ? L_R : (t < 11) ? L_G : (t < 13) ? L_Y : L_R;
            apply(n, e, 1'b0);
            check_errs("legal_errs", 4'b0000);
         end
      end
      check("legal_fault", {15'd0, fault}, 16'd0);
      check("legal_count", cycle_count, 16'd3);

      // 2: conflict, then clear and resync
      apply(L_G, L_R, 1'b0);
      check_errs("pre_conflict", 4'b0000);
      apply(L_G, L_G, 1'b0);
      check_errs("conflict", 4'b0100);
      check("conflict_fault", {15'd0, fault}, 16'd1);
      apply(L_G, L_R, 1'b0);
      check_errs("after_conflict_ew_back", 4'b0011);
      check("fault_sticky", {15'd0, fault}, 16'd1);
      check("count_frozen", cycle_count, 16'd3);
      apply(L_G, L_R, 1'b1);
      check_errs("clear_errs", 4'b0000);
      check("clear_fault", {15'd0, fault}, 16'd0);
      apply(L_G, L_R, 1'b0);
      check_errs("resync", 4'b0000);

      // 3: sequence errors (G->R proves the resync reached RUN)
      apply(L_R, L_R, 1'b0);
      check_errs("seq_g_to_r", 4'b0011);
      check("seq_fault", {15'd0, fault}, 16'd1);
      apply(L_R, L_R, 1'b1);
      check("seq_clear", {15'd0, fault}, 16'd0);
      apply(L_R, L_R, 1'b0);
      apply(L_Y, L_R, 1'b0);
      check_errs("seq_r_to_y", 4'b0010);
      check("seq_ns_phase", {14'd0, ns_phase}, 16'd2);
      apply(L_R, L_R, 1'b1);
      check_errs("clear_wins", 4'b0000);
      apply(L_R, L_R, 1'b0);

      // 4: short green, then green held past MAX_GREEN
      apply(L_G, L_R, 1'b0);
      apply(L_G, L_R, 1'b0);
      check_errs("green2_hold", 4'b0000);
      apply(L_Y, L_R, 1'b0);
      check_errs("short_green", 4'b0001);
      apply(L_R, L_R, 1'b1);
      check("short_clear", {15'd0, fault}, 16'd0);
      apply(L_R, L_R, 1'b0);
      for (int i = 1; i <= 17; i++) begin
         apply(L_G, L_R, 1'b0);
         check("long_green", {15'd0, err_timing}, (i == 17) ? 16'd1 : 16'd0);
      end
      apply(L_G, L_R, 1'b0);
      check_errs("long_green_once", 4'b0000);
      check("long_green_fault", {15'd0, fault}, 16'd1);

      // 5: invalid lamp triple, then green accepted without sequence error
      apply(L_G, L_R, 1'b1);
      apply(L_G, L_R, 1'b0);
      check("onehot_pre_fault", {15'd0, fault}, 16'd0);
      apply(L_BAD, L_R, 1'b0);
      check_errs("onehot", 4'b1000);
      check("onehot_phase", {14'd0, ns_phase}, 16'd3);
      apply(L_G, L_R, 1'b0);
      check_errs("after_invalid", 4'b0000);
      check("after_invalid_phase", {14'd0, ns_phase}, 16'd1);
      check("onehot_fault", {15'd0, fault}, 16'd1);

      // 6: asynchronous reset between edges while faulted
      #2;
      rst_n = 1'b0;
      #1;
      check("areset_fault", {15'd0, fault}, 16'd0);
      check("areset_count", cycle_count, 16'd0);
      check("areset_phase", {12'd0, ns_phase, ew_phase}, 16'd0);
      check_errs("areset_errs", 4'b0000);
      #1;
      rst_n = 1'b1;
      apply(L_G, L_G, 1'b0);
      check_errs("sync_ignore_conflict", 4'b0000);
      apply(L_BAD, L_R, 1'b0);
      check_errs("sync_ignore_onehot", 4'b0000);
      check("sync_fault", {15'd0, fault}, 16'd0);
      apply(L_R, L_R, 1'b0);
      check_errs("sync_sample", 4'b0000);
      apply(L_Y, L_R, 1'b0);
      check_errs("post_reset_run", 4'b0010);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
